// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath mux selects, strobes and 4-bit ALU op. It handshakes with a
// variable-latency unified memory, counts retired instructions and halts on
// ECALL when x17==10.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   opcode/funct3/funct7_5 instruction fields from IR (valid from DECODE)
//   alu_bcond             branch-condition result from the ALU
//   mem_ready             memory completes the current request this cycle
//   ecall_halt            register file reports x17==10
//   alu_select            0 add,1 sub,2 sll,3 xor,4 or,5 and,6 srl,7-10 beq/bne/blt/bge
//   alu_src_a/alu_src_b   operand selects (a: 0=PC,1=rs1; b: 0=rs2,1=imm)
//   mem_req/mem_write     memory request (held until mem_ready) / store
//   i_or_d                memory address select (0=PC, 1=ALUOut)
//   ir_write              latch IR
//   reg_write/wb_sel      register write and source (0 ALUOut,1 MDR,2 PC+4)
//   pc_write/pc_source    PC update and source (0 PC+4,1 ALUOut,2 alu_result)
//   halted/illegal_instr  sticky status flags
//   retired_cnt           retired instruction count (wraps)
//   state_dbg             FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_bcond,
    input  logic             mem_ready,
    input  logic             ecall_halt,
    output logic [3:0]       alu_select,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t state, next_state;
    logic   retire, set_illegal;

    logic is_r, is_i, is_load, is_store, is_br, known_op;
    logic alu_ok, br_ok, bad_instr;
    logic [3:0] alu_op, br_op;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_br    = (opcode == OP_BRANCH);
    assign known_op = is_r || is_i || is_load || is_store || is_br ||
                      (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_ECALL);

    // Only SRL is supported on 101, so funct7_5=1 there means SRA (unsupported).
    // For R-type, funct7_5=1 is only meaningful as SUB.
    assign alu_ok = !(funct3 == 3'b010 || funct3 == 3'b011) &&
                    !(funct3 == 3'b101 && funct7_5) &&
                    !(is_r && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101);
    assign br_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
    assign bad_instr = !known_op || ((is_r || is_i) && !alu_ok) || (is_br && !br_ok);

    always_comb begin
        case (funct3)
            3'b000:  alu_op = (is_r && funct7_5) ? 4'd1 : 4'd0;  // addi never subtracts
            3'b001:  alu_op = 4'd2;
            3'b100:  alu_op = 4'd3;
            3'b110:  alu_op = 4'd4;
            3'b111:  alu_op = 4'd5;
            3'b101:  alu_op = 4'd6;
            default: alu_op = 4'd0;
        endcase
        case (funct3)
            3'b001:  br_op = 4'd8;
            3'b100:  br_op = 4'd9;
            3'b101:  br_op = 4'd10;
            default: br_op = 4'd7;
        endcase
    end

    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        alu_select  = 4'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 2'd0;
        pc_write    = 1'b0;
        pc_source   = 2'd0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculative PC+imm into ALUOut for branches/JAL.
                alu_src_b = 1'b1;
                if (opcode == OP_ECALL && ecall_halt) begin
                    next_state = S_HALT;
                end else if (opcode == OP_ECALL || bad_instr) begin
                    pc_write    = 1'b1;
                    retire      = 1'b1;
                    set_illegal = bad_instr;
                    next_state  = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                next_state = S_FETCH;
                if (is_r) begin
                    alu_select = alu_op;
                    next_state = S_WB;
                end else if (is_i) begin
                    alu_select = alu_op;
                    alu_src_b  = 1'b1;
                    next_state = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b  = 1'b1;
                    next_state = S_MEM;
                end else if (is_br) begin
                    alu_select = br_op;
                    pc_write   = 1'b1;
                    pc_source  = alu_bcond ? 2'd1 : 2'd0;
                    retire     = 1'b1;
                end else if (opcode == OP_JAL) begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_source = 2'd1;
                    retire    = 1'b1;
                end else begin
                    // JALR: target comes straight off the ALU this cycle.
                    alu_src_b = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        next_state = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = is_load ? 2'd1 : 2'd0;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_HALT;
        endcase
        if (!reset_n) begin
            alu_select = 4'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 1'b0;
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            wb_sel     = 2'd0;
            pc_write   = 1'b0;
            pc_source  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_FETCH;
            illegal_instr <= 1'b0;
            retired_cnt   <= '0;
        end else begin
            state <= next_state;
            if (set_illegal) illegal_instr <= 1'b1;
            if (retire) retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // HALT is only left through reset, so the state itself is the sticky flag.
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5, alu_bcond, mem_ready, ecall_halt;
    logic [3:0]  alu_select;
    logic        alu_src_a, alu_src_b, mem_req, mem_write, i_or_d, ir_write, reg_write;
    logic [1:0]  wb_sel, pc_source;
    logic        pc_write, halted, illegal_instr;
    logic [31:0] retired_cnt;
    logic [2:0]  state_dbg;
    logic [15:0] strobes;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
        .ecall_halt(ecall_halt), .alu_select(alu_select), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_source(pc_source),
        .halted(halted), .illegal_instr(illegal_instr),
        .retired_cnt(retired_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign strobes = {alu_select, alu_src_a, alu_src_b, mem_req, mem_write, i_or_d,
                      ir_write, reg_write, wb_sel, pc_write, pc_source};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        alu_bcond = 1'b0; mem_ready = 1'b1; ecall_halt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_strobes", 32'(strobes), 0);
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal_instr), 0);
        chk("rst_cnt", retired_cnt, 0);

        // R-type SUB, memory always ready
        reset_n = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        #1;
        chk("fetch_req", 32'(mem_req), 1);
        chk("fetch_irw", 32'(ir_write), 1);
        chk("fetch_iord", 32'(i_or_d), 0);
        step();
        chk("sub_dec_state", 32'(state_dbg), 1);
        chk("sub_dec_srca", 32'(alu_src_a), 0);
        chk("sub_dec_srcb", 32'(alu_src_b), 1);
        chk("sub_dec_sel", 32'(alu_select), 0);
        step();
        chk("sub_ex_state", 32'(state_dbg), 2);
        chk("sub_ex_sel", 32'(alu_select), 1);
        chk("sub_ex_srca", 32'(alu_src_a), 1);
        chk("sub_ex_srcb", 32'(alu_src_b), 0);
        step();
        chk("sub_wb_state", 32'(state_dbg), 4);
        chk("sub_wb_rw", 32'(reg_write), 1);
        chk("sub_wb_sel", 32'(wb_sel), 0);
        chk("sub_wb_pcw", 32'(pc_write), 1);
        chk("sub_wb_pcs", 32'(pc_source), 0);
        step();
        chk("sub_done_state", 32'(state_dbg), 0);
        chk("sub_cnt", retired_cnt, 1);

        // LOAD with 3 fetch wait cycles and 2 memory wait cycles
        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ld_fwait_state", 32'(state_dbg), 0);
            chk("ld_fwait_req", 32'(mem_req), 1);
            chk("ld_fwait_irw", 32'(ir_write), 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_fetch_irw", 32'(ir_write), 1);
        chk("ld_fetch_req", 32'(mem_req), 1);
        step();
        chk("ld_dec_state", 32'(state_dbg), 1);
        step();
        chk("ld_ex_state", 32'(state_dbg), 2);
        chk("ld_ex_srcb", 32'(alu_src_b), 1);
        chk("ld_ex_sel", 32'(alu_select), 0);
        step();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("ld_mwait_state", 32'(state_dbg), 3);
            chk("ld_mwait_req", 32'(mem_req), 1);
            chk("ld_mwait_iord", 32'(i_or_d), 1);
            chk("ld_mwait_wr", 32'(mem_write), 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_mem_req", 32'(mem_req), 1);
        step();
        chk("ld_wb_state", 32'(state_dbg), 4);
        chk("ld_wb_sel", 32'(wb_sel), 1);
        chk("ld_wb_rw", 32'(reg_write), 1);
        step();
        chk("ld_done_state", 32'(state_dbg), 0);
        chk("ld_cnt", retired_cnt, 2);

        // BEQ taken
        opcode = 7'b1100011; funct3 = 3'b000; alu_bcond = 1'b1;
        step();
        step();
        chk("beq_ex_state", 32'(state_dbg), 2);
        chk("beq_sel", 32'(alu_select), 7);
        chk("beq_pcw", 32'(pc_write), 1);
        chk("beq_pcs", 32'(pc_source), 1);
        chk("beq_srcb", 32'(alu_src_b), 0);
        step();
        chk("beq_done_state", 32'(state_dbg), 0);
        chk("beq_cnt", retired_cnt, 3);

        // BNE not taken
        funct3 = 3'b001; alu_bcond = 1'b0;
        step();
        step();
        chk("bne_sel", 32'(alu_select), 8);
        chk("bne_pcw", 32'(pc_write), 1);
        chk("bne_pcs", 32'(pc_source), 0);
        step();
        chk("bne_done_state", 32'(state_dbg), 0);
        chk("bne_cnt", retired_cnt, 4);

        // LUI is unsupported: NOP in 2 cycles
        opcode = 7'b0110111; funct3 = 3'b000;
        step();
        chk("lui_dec_state", 32'(state_dbg), 1);
        chk("lui_pcw", 32'(pc_write), 1);
        chk("lui_pcs", 32'(pc_source), 0);
        step();
        chk("lui_done_state", 32'(state_dbg), 0);
        chk("lui_illegal", 32'(illegal_instr), 1);
        chk("lui_cnt", retired_cnt, 5);

        // I-type funct3=010 is unsupported
        opcode = 7'b0010011; funct3 = 3'b010;
        step();
        chk("slti_pcw", 32'(pc_write), 1);
        step();
        chk("slti_done_state", 32'(state_dbg), 0);
        chk("slti_illegal", 32'(illegal_instr), 1);
        chk("slti_cnt", retired_cnt, 6);

        // ADDI with funct7_5=1 must still add
        funct3 = 3'b000; funct7_5 = 1'b1;
        step();
        chk("addi_dec_pcw", 32'(pc_write), 0);
        step();
        chk("addi_ex_state", 32'(state_dbg), 2);
        chk("addi_sel", 32'(alu_select), 0);
        chk("addi_srcb", 32'(alu_src_b), 1);
        step();
        chk("addi_wb_rw", 32'(reg_write), 1);
        step();
        chk("addi_cnt", retired_cnt, 7);
        funct7_5 = 1'b0;

        // JAL
        opcode = 7'b1101111;
        step();
        step();
        chk("jal_rw", 32'(reg_write), 1);
        chk("jal_wbsel", 32'(wb_sel), 2);
        chk("jal_pcw", 32'(pc_write), 1);
        chk("jal_pcs", 32'(pc_source), 1);
        step();
        chk("jal_cnt", retired_cnt, 8);

        // JALR
        opcode = 7'b1100111;
        step();
        step();
        chk("jalr_srca", 32'(alu_src_a), 1);
        chk("jalr_srcb", 32'(alu_src_b), 1);
        chk("jalr_wbsel", 32'(wb_sel), 2);
        chk("jalr_pcs", 32'(pc_source), 2);
        step();
        chk("jalr_cnt", retired_cnt, 9);

        // ECALL without halt retires in 2 cycles
        opcode = 7'b1110011; ecall_halt = 1'b0;
        step();
        chk("ecall_pcw", 32'(pc_write), 1);
        step();
        chk("ecall_state", 32'(state_dbg), 0);
        chk("ecall_cnt", retired_cnt, 10);
        chk("ecall_halted", 32'(halted), 0);

        // STORE interrupted by reset while waiting in MEM
        opcode = 7'b0100011; funct3 = 3'b010;
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        chk("st_mem_state", 32'(state_dbg), 3);
        chk("st_mem_wr", 32'(mem_write), 1);
        chk("st_mem_iord", 32'(i_or_d), 1);
        step();
        chk("st_mem_hold", 32'(state_dbg), 3);
        reset_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state_dbg), 0);
        chk("midrst_illegal", 32'(illegal_instr), 0);
        chk("midrst_cnt", retired_cnt, 0);
        chk("midrst_strobes", 32'(strobes), 0);
        step();
        reset_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rel_req", 32'(mem_req), 1);

        // ECALL with halt: freeze with no strobes
        opcode = 7'b1110011; ecall_halt = 1'b1;
        step();
        chk("halt_dec_pcw", 32'(pc_write), 0);
        step();
        chk("halt_state", 32'(state_dbg), 5);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_cnt", retired_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_strobes", 32'(strobes), 0);
            chk("halt_hold", 32'(state_dbg), 5);
            chk("halt_cnt_hold", retired_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
